// File: rtl/alex_tr_sequencer_if.sv
// Handshake between the T/R sequencer and the Alex SPI serializer.
interface alex_tr_sequencer_if;
    logic        spi_start;
    logic [31:0] spi_word;
    logic        spi_busy;

    modport master (output spi_start, output spi_word, input spi_busy);
    modport slave  (input spi_start, input spi_word, output spi_busy);
endinterface

// File: rtl/alex_tr_sequencer.sv
// Alex T/R sequencer: owns the SPI engine, inserts TR/red-LED bits, and orders
// relay vs RF enable so the relay never switches while RF is driven.
module alex_tr_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 122880,
    parameter int unsigned DRAIN_CYCLES  = 1229,
    parameter int unsigned CNT_W         = 21
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ptt_req,
    input  logic [15:0]           tx_cfg,
    input  logic [15:0]           rx_cfg,
    alex_tr_sequencer_if.master   spi,
    output logic                  tr_state,
    output logic                  tx_enable,
    output logic                  seq_busy
);

    localparam int unsigned WORD_W = 32;
    // tx[12], tx[11] and rx[15] of the combined word all follow the relay state
    localparam logic [WORD_W-1:0] TR_MASK = 32'h1800_8000;

    typedef enum logic [2:0] {
        RX_IDLE,
        CFG_SEND,
        KEY_SEND,
        KEY_SETTLE,
        TX_ACTIVE,
        UNKEY_DRAIN,
        UNKEY_SEND,
        UNKEY_SETTLE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   last_sent_q, last_sent_d;
    logic                init_pending_q, init_pending_d;
    logic                seen_busy_q, seen_busy_d;
    logic                start_d;
    logic [WORD_W-1:0]   word_d;
    logic                tr_d, txen_d, seq_busy_d;

    logic [WORD_W-1:0]   cfg_word_c;
    logic                cfg_dirty_c;
    logic                send_done_c;

    // Masked config word, change detect and serializer completion event
    always_comb begin
        cfg_word_c  = {tx_cfg, rx_cfg} & ~TR_MASK;
        cfg_dirty_c = (cfg_word_c != last_sent_q) || init_pending_q;
        send_done_c = seen_busy_q && !spi.spi_busy;
    end

    // Next-state and registered-output values
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_sent_d    = last_sent_q;
        init_pending_d = init_pending_q;
        seen_busy_d    = seen_busy_q;
        start_d        = 1'b0;
        word_d         = spi.spi_word;
        tr_d           = tr_state;
        txen_d         = tx_enable;

        case (state_q)
            RX_IDLE: begin
                tr_d   = 1'b0;
                txen_d = 1'b0;
                if (!spi.spi_busy) begin
                    if (ptt_req) begin
                        state_d     = KEY_SEND;
                        start_d     = 1'b1;
                        word_d      = cfg_word_c | TR_MASK;
                        tr_d        = 1'b1;
                        seen_busy_d = 1'b0;
                    end else if (cfg_dirty_c) begin
                        state_d     = CFG_SEND;
                        start_d     = 1'b1;
                        word_d      = cfg_word_c;
                        seen_busy_d = 1'b0;
                    end
                end
            end

            CFG_SEND, KEY_SEND, UNKEY_SEND: begin
                if (spi.spi_busy) begin
                    seen_busy_d = 1'b1;
                end
                if (send_done_c) begin
                    last_sent_d    = spi.spi_word & ~TR_MASK;
                    init_pending_d = 1'b0;
                    seen_busy_d    = 1'b0;
                    if (state_q == CFG_SEND) begin
                        state_d = RX_IDLE;
                    end else if (state_q == KEY_SEND) begin
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                        state_d = KEY_SETTLE;
                    end else begin
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                        state_d = UNKEY_SETTLE;
                    end
                end
            end

            KEY_SETTLE: begin
                if (!ptt_req) begin
                    // Aborted before RF was enabled: release relay without drain
                    state_d     = UNKEY_SEND;
                    start_d     = 1'b1;
                    word_d      = cfg_word_c;
                    tr_d        = 1'b0;
                    seen_busy_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = TX_ACTIVE;
                    txen_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            TX_ACTIVE: begin
                txen_d = 1'b1;
                if (!ptt_req) begin
                    txen_d  = 1'b0;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                    state_d = UNKEY_DRAIN;
                end
            end

            UNKEY_DRAIN: begin
                txen_d = 1'b0;
                if (cnt_q == '0) begin
                    // Current cfg goes out here, flushing any change deferred while keyed
                    state_d     = UNKEY_SEND;
                    start_d     = 1'b1;
                    word_d      = cfg_word_c;
                    tr_d        = 1'b0;
                    seen_busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            UNKEY_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase

        seq_busy_d = !((state_d == RX_IDLE) || (state_d == TX_ACTIVE));
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= RX_IDLE;
            cnt_q          <= '0;
            last_sent_q    <= '0;
            init_pending_q <= 1'b1;
            seen_busy_q    <= 1'b0;
            spi.spi_start  <= 1'b0;
            spi.spi_word   <= '0;
            tr_state       <= 1'b0;
            tx_enable      <= 1'b0;
            seq_busy       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_sent_q    <= last_sent_d;
            init_pending_q <= init_pending_d;
            seen_busy_q    <= seen_busy_d;
            spi.spi_start  <= start_d;
            spi.spi_word   <= word_d;
            tr_state       <= tr_d;
            tx_enable      <= txen_d;
            seq_busy       <= seq_busy_d;
        end
    end

endmodule
